// File: rtl/cjump_rs.sv
// cjump_rs: reservation station in front of the conditional-jump functional unit.
// Holds dispatched branch micro-ops until both source operands are present,
// snooping the CDB for producer results, and hands the oldest ready entry to
// the FU through the input_transmit strobe whenever the FU is free.
// The queue is kept collapsed: valid entries always occupy indices
// 0..count-1, with index 0 the oldest.
module cjump_rs #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  // dispatch side
  input  logic            dispatch_valid,
  output logic            dispatch_ready,
  input  logic [7:0]      dispatch_operand,
  input  logic [3:0]      dispatch_robid,
  input  logic [7:0]      dispatch_wbs,
  input  logic [7:0]      dispatch_flags,
  input  logic [1:0]      src_ready,
  input  logic [1:0][3:0] src_tag,
  input  logic [1:0][7:0] src_val,
  // common data bus snoop
  input  logic            cdb_valid,
  input  logic [3:0]      cdb_id,
  input  logic [7:0]      cdb_val,
  // issue side towards the FU
  output logic            input_transmit,
  output logic [7:0]      operand,
  output logic [1:0][7:0] depvals,
  output logic [7:0]      wbs,
  output logic [7:0]      flags,
  output logic [3:0]      robid,
  input  logic            fu_busy
);

  localparam int CW = $clog2(DEPTH + 1);  // holds 0..DEPTH
  localparam int IW = $clog2(DEPTH);      // holds 0..DEPTH-1

  // One source operand: either a value (rdy=1) or the ROB id producing it.
  typedef struct packed {
    logic       rdy;
    logic [3:0] tag;
    logic [7:0] val;
  } src_t;

  // One station slot; src[1] is source a, src[0] is source b.
  typedef struct packed {
    logic            valid;
    logic [7:0]      operand;
    logic [3:0]      robid;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    src_t [1:0]      src;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        new_ent;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic          issue;
  logic          dispatch_fire;

  // Acceptance is based on the registered occupancy only, so a full station
  // refuses a dispatch even in a cycle where it also issues.
  assign dispatch_ready = (count_q < CW'(DEPTH)) && !rst && !flush;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  // Select the lowest-index (oldest) entry whose two sources are both present.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].src[1].rdy && ent_q[i].src[0].rdy) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // The FU takes at most one op every other cycle: a cycle that already shows
  // input_transmit high covers the FU's one-cycle delay in raising busy.
  assign issue = sel_found && !fu_busy && !input_transmit && !flush && !rst;

  // A new dispatch lands at the first free slot after any same-cycle collapse.
  assign wr_idx = count_q - CW'(issue);

  // Build the incoming entry, capturing a result broadcast in the same cycle
  // so an op whose producer completes right now does not wait forever.
  always_comb begin
    new_ent.valid   = 1'b1;
    new_ent.operand = dispatch_operand;
    new_ent.robid   = dispatch_robid;
    new_ent.wbs     = dispatch_wbs;
    new_ent.flags   = dispatch_flags;
    for (int s = 0; s < 2; s++) begin
      new_ent.src[s].tag = src_tag[s];
      if (!src_ready[s] && cdb_valid && (cdb_id == src_tag[s])) begin
        new_ent.src[s].rdy = 1'b1;
        new_ent.src[s].val = cdb_val;
      end else begin
        new_ent.src[s].rdy = src_ready[s];
        new_ent.src[s].val = src_val[s];
      end
    end
  end

  // Next station contents: collapse over the issued slot, apply CDB wakeup at
  // the post-shift positions, then append the dispatched entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end

    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          ent_d[i] = ent_q[i + 1];
        end
      end
      // Top slot is either the issued one or has just moved down.
      ent_d[DEPTH-1].valid = 1'b0;
    end

    // The issued entry has already left the array, so it cannot wake here.
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (ent_d[i].valid && !ent_d[i].src[s].rdy && cdb_valid &&
            (ent_d[i].src[s].tag == cdb_id)) begin
          ent_d[i].src[s].rdy = 1'b1;
          ent_d[i].src[s].val = cdb_val;
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (dispatch_fire && (CW'(i) == wr_idx)) begin
        ent_d[i] = new_ent;
      end
    end

    count_d = count_q + CW'(dispatch_fire) - CW'(issue);
  end

  // Station state and the registered FU issue port.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: only the valid bits are cleared; slot payloads are don't-care
      // while invalid, so they carry no reset and stay plain storage.
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
      end
      count_q        <= '0;
      input_transmit <= 1'b0;
      operand        <= '0;
      depvals        <= '0;
      wbs            <= '0;
      flags          <= '0;
      robid          <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q        <= count_d;
      input_transmit <= issue;
      // Payload registers hold their last values between issues.
      for (int i = 0; i < DEPTH; i++) begin
        if (issue && (IW'(i) == sel_idx)) begin
          operand    <= ent_q[i].operand;
          depvals[1] <= ent_q[i].src[1].val;
          depvals[0] <= ent_q[i].src[0].val;
          wbs        <= ent_q[i].wbs;
          flags      <= ent_q[i].flags;
          robid      <= ent_q[i].robid;
        end
      end
    end
  end

  // Structural invariants of the collapsing queue.
  a_count_range : assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  a_no_back_to_back : assert property (@(posedge clk) disable iff (rst)
    input_transmit |=> !input_transmit);

  for (genvar g = 0; g < DEPTH; g++) begin : g_compact
    a_compact : assert property (@(posedge clk) disable iff (rst)
      ent_q[g].valid == (CW'(g) < count_q));
  end

endmodule

// File: tb/tb_cjump_rs.sv
// Self-checking bench for cjump_rs: directed dispatch/CDB/busy/flush vectors,
// with expected issues queued at stimulus time and checked by a monitor
// whenever input_transmit is seen high.
module tb_cjump_rs;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            dispatch_valid;
  logic            dispatch_ready;
  logic [7:0]      dispatch_operand;
  logic [3:0]      dispatch_robid;
  logic [7:0]      dispatch_wbs;
  logic [7:0]      dispatch_flags;
  logic [1:0]      src_ready;
  logic [1:0][3:0] src_tag;
  logic [1:0][7:0] src_val;
  logic            cdb_valid;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;
  logic            input_transmit;
  logic [7:0]      operand;
  logic [1:0][7:0] depvals;
  logic [7:0]      wbs;
  logic [7:0]      flags;
  logic [3:0]      robid;
  logic            fu_busy;

  cjump_rs #(.DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_operand (dispatch_operand),
    .dispatch_robid   (dispatch_robid),
    .dispatch_wbs     (dispatch_wbs),
    .dispatch_flags   (dispatch_flags),
    .src_ready        (src_ready),
    .src_tag          (src_tag),
    .src_val          (src_val),
    .cdb_valid        (cdb_valid),
    .cdb_id           (cdb_id),
    .cdb_val          (cdb_val),
    .input_transmit   (input_transmit),
    .operand          (operand),
    .depvals          (depvals),
    .wbs              (wbs),
    .flags            (flags),
    .robid            (robid),
    .fu_busy          (fu_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] robid;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;   // posedge count at which the strobe must appear
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // wbs and flags are derived from the ROB id so each op carries distinct bytes.
  function automatic logic [7:0] wbs_of(input logic [3:0] rid);
    return {4'h2, rid};
  endfunction

  function automatic logic [7:0] flags_of(input logic [3:0] rid);
    return {rid, 4'hC};
  endfunction

  function automatic void push(input logic [3:0] rid, input logic [7:0] op,
                               input logic [7:0] a, input logic [7:0] b, input int c);
    exp_t e;
    e.robid = rid; e.op = op; e.a = a; e.b = b; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (input_transmit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_issue: got robid 0x%0h operand 0x%0h expected no issue (cycle %0d)",
                 robid, operand, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_payload",
              {20'h0, robid, operand, depvals[1], depvals[0], wbs, flags},
              {20'h0, e.robid, e.op, e.a, e.b, wbs_of(e.robid), flags_of(e.robid)});
        if (e.cyc >= 0) check("issue_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [3:0] rid, input logic [7:0] op, input logic [1:0] rdy,
                          input logic [3:0] ta, input logic [3:0] tb,
                          input logic [7:0] va, input logic [7:0] vb);
    dispatch_valid   = 1'b1;
    dispatch_robid   = rid;
    dispatch_operand = op;
    dispatch_wbs     = wbs_of(rid);
    dispatch_flags   = flags_of(rid);
    src_ready        = rdy;
    src_tag[1]       = ta;
    src_tag[0]       = tb;
    src_val[1]       = va;
    src_val[0]       = vb;
  endtask

  task automatic clr_disp();
    dispatch_valid = 1'b0;
    src_ready      = 2'b00;
    src_tag        = '0;
    src_val        = '0;
  endtask

  task automatic dispatch(input logic [3:0] rid, input logic [7:0] op, input logic [1:0] rdy,
                          input logic [3:0] ta, input logic [3:0] tb,
                          input logic [7:0] va, input logic [7:0] vb);
    set_disp(rid, op, rdy, ta, tb, va, vb);
    tick();
    clr_disp();
  endtask

  // Bounded wait for all expected issues; an expired bound counts as a failure.
  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d issues outstanding expected 0 (cycle %0d)",
               exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; flush = 1'b0; fu_busy = 1'b0;
    cdb_valid = 1'b0; cdb_id = '0; cdb_val = '0;
    dispatch_operand = '0; dispatch_robid = '0; dispatch_wbs = '0; dispatch_flags = '0;
    clr_disp();

    // Reset state
    repeat (3) tick();
    check("rst_ready", 64'(dispatch_ready), 64'd0);
    check("rst_transmit", 64'(input_transmit), 64'd0);
    check("rst_payload", {20'h0, robid, operand, depvals[1], depvals[0], wbs, flags}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(dispatch_ready), 64'd1);

    // Single fully-ready op: strobe two edges after dispatch, payload then holds.
    push(4'd3, 8'h05, 8'h80, 8'h42, cyc + 2);
    dispatch(4'd3, 8'h05, 2'b11, 4'd0, 4'd0, 8'h80, 8'h42);
    drain(20);
    tick();
    check("hold_operand", 64'(operand), 64'h05);
    check("transmit_low", 64'(input_transmit), 64'd0);
    check("empty_ready", 64'(dispatch_ready), 64'd1);

    // Younger ready op bypasses older op waiting on tag 7; wrong tag wakes nothing.
    dispatch(4'd1, 8'h61, 2'b01, 4'd7, 4'd0, 8'h00, 8'h22);
    push(4'd2, 8'h62, 8'h44, 8'h55, cyc + 2);
    dispatch(4'd2, 8'h62, 2'b11, 4'd0, 4'd0, 8'h44, 8'h55);
    repeat (2) tick();
    cdb_valid = 1'b1; cdb_id = 4'd6; cdb_val = 8'hEE;
    tick();
    cdb_valid = 1'b0;
    repeat (3) tick();
    push(4'd1, 8'h61, 8'h11, 8'h22, cyc + 2);
    cdb_valid = 1'b1; cdb_id = 4'd7; cdb_val = 8'h11;
    tick();
    cdb_valid = 1'b0;
    drain(20);

    // Fill all four slots waiting on tag 5; a dispatch while full is dropped.
    for (int k = 0; k < 4; k++)
      dispatch(4'(8 + k), 8'(8'h70 + k), 2'b00, 4'd5, 4'd5, 8'h00, 8'h00);
    check("full_ready", 64'(dispatch_ready), 64'd0);
    dispatch(4'd15, 8'hFF, 2'b11, 4'd0, 4'd0, 8'h01, 8'h02);
    check("full_ready_held", 64'(dispatch_ready), 64'd0);
    c = cyc;
    for (int k = 0; k < 4; k++)
      push(4'(8 + k), 8'(8'h70 + k), 8'h5A, 8'h5A, c + 2 + 2 * k);
    cdb_valid = 1'b1; cdb_id = 4'd5; cdb_val = 8'h5A;
    tick();
    cdb_valid = 1'b0;
    check("ready_before_issue", 64'(dispatch_ready), 64'd0);
    tick();
    check("ready_after_issue", 64'(dispatch_ready), 64'd1);
    drain(30);

    // Same-cycle CDB bypass on source b; ready source a keeps its own value.
    push(4'd4, 8'h44, 8'h33, 8'hAA, cyc + 2);
    cdb_valid = 1'b1; cdb_id = 4'd9; cdb_val = 8'hAA;
    dispatch(4'd4, 8'h44, 2'b10, 4'd9, 4'd9, 8'h33, 8'h00);
    cdb_valid = 1'b0;
    drain(20);

    // FU busy holds off issue; oldest goes on the first edge after release.
    fu_busy = 1'b1;
    dispatch(4'd10, 8'hA0, 2'b11, 4'd0, 4'd0, 8'h10, 8'h01);
    dispatch(4'd11, 8'hA1, 2'b11, 4'd0, 4'd0, 8'h11, 8'h02);
    dispatch(4'd12, 8'hA2, 2'b11, 4'd0, 4'd0, 8'h12, 8'h03);
    repeat (10) tick();
    c = cyc;
    push(4'd10, 8'hA0, 8'h10, 8'h01, c + 1);
    push(4'd11, 8'hA1, 8'h11, 8'h02, c + 3);
    push(4'd12, 8'hA2, 8'h12, 8'h03, c + 5);
    fu_busy = 1'b0;
    drain(30);

    // Flush with three entries and a concurrent dispatch: nothing survives.
    fu_busy = 1'b1;
    dispatch(4'd13, 8'hB0, 2'b11, 4'd0, 4'd0, 8'h20, 8'h21);
    dispatch(4'd14, 8'hB1, 2'b11, 4'd0, 4'd0, 8'h22, 8'h23);
    dispatch(4'd15, 8'hB2, 2'b11, 4'd0, 4'd0, 8'h24, 8'h25);
    set_disp(4'd6, 8'hC6, 2'b11, 4'd0, 4'd0, 8'h26, 8'h27);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(dispatch_ready), 64'd0);
    tick();
    flush = 1'b0;
    clr_disp();
    #1;
    check("post_flush_ready", 64'(dispatch_ready), 64'd1);
    check("post_flush_payload", {52'h0, robid, operand}, 64'd0);
    fu_busy = 1'b0;
    repeat (10) tick();

    // Reset while a strobe is high: strobe drops, pending entry is discarded.
    c = cyc;
    push(4'd7, 8'h77, 8'h01, 8'h02, c + 2);
    dispatch(4'd7, 8'h77, 2'b11, 4'd0, 4'd0, 8'h01, 8'h02);
    dispatch(4'd2, 8'h22, 2'b11, 4'd0, 4'd0, 8'h03, 8'h04);
    check("transmit_before_rst", 64'(input_transmit), 64'd1);
    rst = 1'b1;
    tick();
    check("transmit_after_rst", 64'(input_transmit), 64'd0);
    rst = 1'b0;
    repeat (10) tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish by 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
